// File: rtl/sram_arb2_ctrl.sv
// Two-requester round-robin front end for a single-port SRAM macro.
// Zero-fills the whole array after reset, then arbitrates one command per cycle.
module sram_arb2_ctrl #(
    parameter int ADDR_WIDTH  = 6,
    parameter int DATA_WIDTH  = 32,
    parameter int WMASK_WIDTH = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   req0_valid,
    output logic                   req0_ready,
    input  logic                   req0_we,
    input  logic [WMASK_WIDTH-1:0] req0_wmask,
    input  logic [ADDR_WIDTH-1:0]  req0_addr,
    input  logic [DATA_WIDTH-1:0]  req0_wdata,
    input  logic                   req1_valid,
    output logic                   req1_ready,
    input  logic                   req1_we,
    input  logic [WMASK_WIDTH-1:0] req1_wmask,
    input  logic [ADDR_WIDTH-1:0]  req1_addr,
    input  logic [DATA_WIDTH-1:0]  req1_wdata,
    output logic                   rsp0_valid,
    output logic [DATA_WIDTH-1:0]  rsp0_rdata,
    output logic                   rsp1_valid,
    output logic [DATA_WIDTH-1:0]  rsp1_rdata,
    output logic                   sram_we,
    output logic [WMASK_WIDTH-1:0] sram_wmask,
    output logic [ADDR_WIDTH-1:0]  sram_addr,
    output logic [DATA_WIDTH-1:0]  sram_din,
    input  logic [DATA_WIDTH-1:0]  sram_dout,
    output logic                   init_done,
    output logic                   state_dbg
);

    // Handshake: a command transfers in any cycle where reqN_valid && reqN_ready;
    // ready never waits on anything but valid and the priority bit, and an
    // ungranted requester must hold its command unchanged.
    typedef enum logic {INIT, RUN} state_t;

    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = '1;

    state_t                 state, state_nxt;
    logic [ADDR_WIDTH-1:0]  cnt;
    logic                   prio;   // 1: req1 wins the next contest
    logic                   pend0, pend1;
    logic                   gnt0, gnt1;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= INIT;
            cnt   <= '0;
            prio  <= 1'b0;
            pend0 <= 1'b0;
            pend1 <= 1'b0;
        end else begin
            state <= state_nxt;
            if (state == INIT) begin
                cnt <= cnt + 1'b1;
            end
            if (gnt0 || gnt1) begin
                prio <= gnt0;
            end
            pend0 <= gnt0 && !req0_we;
            pend1 <= gnt1 && !req1_we;
        end
    end

    always_comb begin
        gnt0 = 1'b0;
        gnt1 = 1'b0;
        if (!rst && state == RUN) begin
            if (req0_valid && req1_valid) begin
                gnt0 = !prio;
                gnt1 = prio;
            end else begin
                gnt0 = req0_valid;
                gnt1 = req1_valid;
            end
        end
    end

    // Reset gates every output so the macro sees no stray write while rst is high.
    always_comb begin
        state_nxt  = state;
        sram_we    = 1'b0;
        sram_wmask = '0;
        sram_addr  = '0;
        sram_din   = '0;
        if (!rst) begin
            if (state == INIT) begin
                sram_we    = 1'b1;
                sram_wmask = '1;
                sram_addr  = cnt;
                if (cnt == LAST_ADDR) begin
                    state_nxt = RUN;
                end
            end else if (gnt0) begin
                sram_we    = req0_we;
                sram_wmask = req0_wmask;
                sram_addr  = req0_addr;
                sram_din   = req0_wdata;
            end else if (gnt1) begin
                sram_we    = req1_we;
                sram_wmask = req1_wmask;
                sram_addr  = req1_addr;
                sram_din   = req1_wdata;
            end
        end
    end

    assign req0_ready = gnt0;
    assign req1_ready = gnt1;
    assign rsp0_valid = pend0 && !rst;
    assign rsp1_valid = pend1 && !rst;
    assign rsp0_rdata = rsp0_valid ? sram_dout : '0;
    assign rsp1_rdata = rsp1_valid ? sram_dout : '0;
    assign init_done  = (state == RUN) && !rst;
    assign state_dbg  = (state == RUN);

endmodule

// File: tb/tb_sram_arb2_ctrl.sv
// Directed bench for sram_arb2_ctrl with a behavioural byte-masked SRAM model.
module tb_sram_arb2_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req0_valid, req0_ready, req0_we;
    logic [3:0]  req0_wmask;
    logic [5:0]  req0_addr;
    logic [31:0] req0_wdata;
    logic        req1_valid, req1_ready, req1_we;
    logic [3:0]  req1_wmask;
    logic [5:0]  req1_addr;
    logic [31:0] req1_wdata;
    logic        rsp0_valid, rsp1_valid;
    logic [31:0] rsp0_rdata, rsp1_rdata;
    logic        sram_we;
    logic [3:0]  sram_wmask;
    logic [5:0]  sram_addr;
    logic [31:0] sram_din;
    logic [31:0] sram_dout = 32'h0;
    logic        init_done, state_dbg;

    logic [31:0] mem [64];
    int n_chk  = 0;
    int n_fail = 0;

    localparam logic [31:0] DAT_A = 32'hCAFE0010;
    localparam logic [31:0] DAT_B = 32'h5A5A0011;

    always #5 clk = ~clk;

    sram_arb2_ctrl dut (
        .clk(clk), .rst(rst),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_we(req0_we),
        .req0_wmask(req0_wmask), .req0_addr(req0_addr), .req0_wdata(req0_wdata),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_we(req1_we),
        .req1_wmask(req1_wmask), .req1_addr(req1_addr), .req1_wdata(req1_wdata),
        .rsp0_valid(rsp0_valid), .rsp0_rdata(rsp0_rdata),
        .rsp1_valid(rsp1_valid), .rsp1_rdata(rsp1_rdata),
        .sram_we(sram_we), .sram_wmask(sram_wmask), .sram_addr(sram_addr),
        .sram_din(sram_din), .sram_dout(sram_dout),
        .init_done(init_done), .state_dbg(state_dbg)
    );

    // Registered-output SRAM: read-before-write, data appears the cycle after the address.
    always @(posedge clk) begin
        sram_dout <= mem[sram_addr];
        if (sram_we) begin
            for (int b = 0; b < 4; b++) begin
                if (sram_wmask[b]) mem[sram_addr][b*8 +: 8] <= sram_din[b*8 +: 8];
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic set0(input logic v, input logic we, input logic [3:0] m,
                        input logic [5:0] a, input logic [31:0] d);
        req0_valid = v; req0_we = we; req0_wmask = m; req0_addr = a; req0_wdata = d;
    endtask

    task automatic set1(input logic v, input logic we, input logic [3:0] m,
                        input logic [5:0] a, input logic [31:0] d);
        req1_valid = v; req1_we = we; req1_wmask = m; req1_addr = a; req1_wdata = d;
    endtask

    task automatic mid();
        @(negedge clk);
    endtask

    task automatic next();
        @(posedge clk);
        #1;
    endtask

    initial begin
        for (int i = 0; i < 64; i++) mem[i] = $urandom;
        // Contest commands are already presented during reset and INIT.
        set0(1'b1, 1'b1, 4'hF, 6'd10, DAT_A);
        set1(1'b1, 1'b1, 4'hF, 6'd11, DAT_B);
        next();
        mid();
        chk("rst_sram_we", 32'(sram_we), 0);
        chk("rst_sram_wmask", 32'(sram_wmask), 0);
        chk("rst_ready0", 32'(req0_ready), 0);
        chk("rst_ready1", 32'(req1_ready), 0);
        chk("rst_rsp0_valid", 32'(rsp0_valid), 0);
        chk("rst_init_done", 32'(init_done), 0);
        next();
        rst = 1'b0;

        for (int k = 0; k < 64; k++) begin
            mid();
            chk("init_we", 32'(sram_we), 1);
            chk("init_wmask", 32'(sram_wmask), 32'hF);
            chk("init_addr", 32'(sram_addr), 32'(k));
            chk("init_din", sram_din, 0);
            chk("init_ready0", 32'(req0_ready), 0);
            chk("init_ready1", 32'(req1_ready), 0);
            chk("init_done_low", 32'(init_done), 0);
            next();
        end

        // First contest after reset goes to req0, then req1 alone.
        mid();
        chk("run_init_done", 32'(init_done), 1);
        chk("contest_ready0", 32'(req0_ready), 1);
        chk("contest_ready1", 32'(req1_ready), 0);
        chk("contest_addr", 32'(sram_addr), 10);
        chk("contest_din", sram_din, DAT_A);
        next();
        set0(1'b0, 1'b0, 4'h0, 6'd0, 32'h0);
        mid();
        chk("single1_ready1", 32'(req1_ready), 1);
        chk("single1_addr", 32'(sram_addr), 11);
        chk("single1_din", sram_din, DAT_B);
        next();

        // Continuous contested reads alternate, one response per cycle.
        set0(1'b1, 1'b0, 4'h0, 6'd10, 32'h0);
        set1(1'b1, 1'b0, 4'h0, 6'd11, 32'h0);
        for (int i = 0; i < 6; i++) begin
            mid();
            chk("alt_ready0", 32'(req0_ready), 32'(i % 2 == 0));
            chk("alt_ready1", 32'(req1_ready), 32'(i % 2 == 1));
            chk("alt_addr", 32'(sram_addr), (i % 2 == 0) ? 10 : 11);
            chk("alt_we", 32'(sram_we), 0);
            if (i > 0) begin
                chk("alt_rsp0_valid", 32'(rsp0_valid), 32'((i - 1) % 2 == 0));
                chk("alt_rsp1_valid", 32'(rsp1_valid), 32'((i - 1) % 2 == 1));
                chk("alt_rsp0_rdata", rsp0_rdata, ((i - 1) % 2 == 0) ? DAT_A : 32'h0);
                chk("alt_rsp1_rdata", rsp1_rdata, ((i - 1) % 2 == 1) ? DAT_B : 32'h0);
            end
            next();
        end
        set0(1'b0, 1'b0, 4'h0, 6'd0, 32'h0);
        set1(1'b0, 1'b0, 4'h0, 6'd0, 32'h0);
        mid();
        chk("alt_last_rsp1_valid", 32'(rsp1_valid), 1);
        chk("alt_last_rsp1_rdata", rsp1_rdata, DAT_B);
        chk("alt_last_rsp0_valid", 32'(rsp0_valid), 0);
        chk("idle_addr", 32'(sram_addr), 0);
        chk("idle_wmask", 32'(sram_wmask), 0);
        chk("idle_din", sram_din, 0);
        next();

        // Zero-fill readback of the last address.
        set0(1'b1, 1'b0, 4'h0, 6'd63, 32'h0);
        mid();
        chk("rd63_ready0", 32'(req0_ready), 1);
        chk("rd63_addr", 32'(sram_addr), 63);
        next();
        set0(1'b0, 1'b0, 4'h0, 6'd0, 32'h0);
        mid();
        chk("rd63_rsp0_valid", 32'(rsp0_valid), 1);
        chk("rd63_rsp0_rdata", rsp0_rdata, 0);
        chk("rd63_rsp1_valid", 32'(rsp1_valid), 0);
        next();

        // Write then immediate read from the other requester.
        set0(1'b1, 1'b1, 4'hF, 6'd5, 32'hDEADBEEF);
        mid();
        chk("w5_ready0", 32'(req0_ready), 1);
        chk("w5_we", 32'(sram_we), 1);
        chk("w5_din", sram_din, 32'hDEADBEEF);
        next();
        set0(1'b0, 1'b0, 4'h0, 6'd0, 32'h0);
        set1(1'b1, 1'b0, 4'h0, 6'd5, 32'h0);
        mid();
        chk("r5_ready1", 32'(req1_ready), 1);
        chk("r5_ready0", 32'(req0_ready), 0);
        chk("w5_no_rsp0", 32'(rsp0_valid), 0);
        next();
        set1(1'b0, 1'b0, 4'h0, 6'd0, 32'h0);
        mid();
        chk("r5_rsp1_valid", 32'(rsp1_valid), 1);
        chk("r5_rsp1_rdata", rsp1_rdata, 32'hDEADBEEF);
        chk("r5_rsp0_valid", 32'(rsp0_valid), 0);
        chk("r5_rsp0_rdata", rsp0_rdata, 0);
        next();

        // Partial byte-lane write, then an all-zero mask write that must change nothing.
        set1(1'b1, 1'b1, 4'hF, 6'd9, 32'h11223344);
        next();
        set1(1'b0, 1'b0, 4'h0, 6'd0, 32'h0);
        set0(1'b1, 1'b1, 4'b0101, 6'd9, 32'hAABBCCDD);
        mid();
        chk("wm_wmask", 32'(sram_wmask), 32'h5);
        next();
        set0(1'b0, 1'b0, 4'h0, 6'd0, 32'h0);
        set1(1'b1, 1'b1, 4'h0, 6'd9, 32'hFFFFFFFF);
        mid();
        chk("wm0_we", 32'(sram_we), 1);
        chk("wm0_wmask", 32'(sram_wmask), 0);
        chk("wm0_din", sram_din, 32'hFFFFFFFF);
        next();
        set1(1'b0, 1'b0, 4'h0, 6'd0, 32'h0);
        set0(1'b1, 1'b0, 4'h0, 6'd9, 32'h0);
        next();
        set0(1'b0, 1'b0, 4'h0, 6'd0, 32'h0);
        mid();
        chk("r9_rsp0_valid", 32'(rsp0_valid), 1);
        chk("r9_rsp0_rdata", rsp0_rdata, 32'h11BB33DD);
        next();

        // Reset right after a granted read kills its response and restarts INIT.
        set0(1'b1, 1'b0, 4'h0, 6'd5, 32'h0);
        mid();
        chk("rr_ready0", 32'(req0_ready), 1);
        next();
        set0(1'b0, 1'b0, 4'h0, 6'd0, 32'h0);
        rst = 1'b1;
        mid();
        chk("rr_rst_rsp0_valid", 32'(rsp0_valid), 0);
        chk("rr_rst_rsp0_rdata", rsp0_rdata, 0);
        chk("rr_rst_we", 32'(sram_we), 0);
        chk("rr_rst_init_done", 32'(init_done), 0);
        next();
        rst = 1'b0;
        mid();
        chk("rr_after_rsp0_valid", 32'(rsp0_valid), 0);
        chk("rr_after_we", 32'(sram_we), 1);
        chk("rr_after_addr", 32'(sram_addr), 0);
        next();
        for (int k = 1; k < 20; k++) begin
            mid();
            chk("reinit_addr", 32'(sram_addr), 32'(k));
            next();
        end

        // Reset at counter 20 restarts the fill from address 0.
        rst = 1'b1;
        mid();
        chk("mid_rst_we", 32'(sram_we), 0);
        next();
        rst = 1'b0;
        set0(1'b1, 1'b0, 4'h0, 6'd1, 32'h0);
        set1(1'b1, 1'b0, 4'h0, 6'd2, 32'h0);
        for (int k = 0; k < 64; k++) begin
            mid();
            chk("refill_addr", 32'(sram_addr), 32'(k));
            chk("refill_init_done", 32'(init_done), 0);
            next();
        end
        mid();
        chk("refill_done", 32'(init_done), 1);
        chk("prio_reset_ready0", 32'(req0_ready), 1);
        chk("prio_reset_ready1", 32'(req1_ready), 0);
        next();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/sram_arb2_ctrl.md
SRAM_ARB2_CTRL -- requirements
Module: sram_arb2_ctrl

Interface
REQ-001 Parameter ADDR_WIDTH, default 6, SRAM word-address width.
REQ-002 Parameter DATA_WIDTH, default 32, SRAM word width.
REQ-003 Parameter WMASK_WIDTH, default 4, byte-lane write-mask width (DATA_WIDTH/8).
REQ-004 The block SHALL have exactly one clock; reset SHALL be synchronous and active-high.
REQ-005 clk  input  1  clock; all state updates on posedge.
REQ-006 rst  input  1  synchronous active-high reset.
REQ-007 reqN_valid  input  1  requester N (N=0,1) has a command.
REQ-008 reqN_ready  output  1  command of requester N accepted this cycle.
REQ-009 reqN_we  input  1  1 = write, 0 = read.
REQ-010 reqN_wmask  input  WMASK_WIDTH  byte-lane enables for writes.
REQ-011 reqN_addr  input  ADDR_WIDTH  word address.
REQ-012 reqN_wdata  input  DATA_WIDTH  write data.
REQ-013 rspN_valid  output  1  read data for requester N valid this cycle.
REQ-014 rspN_rdata  output  DATA_WIDTH  read data for requester N.
REQ-015 sram_we, sram_wmask, sram_addr, sram_din  outputs  1/WMASK_WIDTH/ADDR_WIDTH/DATA_WIDTH  drive SRAM macro ports of same meaning.
REQ-016 sram_dout  input  DATA_WIDTH  SRAM registered read data.
REQ-017 init_done  output  1  memory zero-fill complete; arbitration enabled.

Function
REQ-018 States SHALL be INIT and RUN; reset enters INIT with init counter 0.
REQ-019 INIT: one write per cycle, sram_we=1, sram_wmask all ones, sram_din=0, sram_addr=counter; counter increments 0..2^ADDR_WIDTH-1.
REQ-020 After the write to the last address, state SHALL go to RUN next cycle; init_done=1 in RUN only; 64 INIT cycles at default parameters.
REQ-021 In INIT both reqN_ready SHALL be 0.
REQ-022 RUN: at most one command granted per cycle; reqN_ready is combinational from reqN_valid and priority state, and SHALL be 1 only for the granted requester.
REQ-023 Single valid requester SHALL be granted that cycle.
REQ-024 Both valid: round-robin; grant the requester not granted most recently; after reset, req0 wins the first contest.
REQ-025 Priority pointer SHALL update only on a grant.
REQ-026 Granted command SHALL drive sram_we/wmask/addr/din combinationally in the grant cycle; SRAM samples at the closing edge.
REQ-027 No grant in RUN: sram_we=0, sram_wmask=0, sram_addr=0, sram_din=0.
REQ-028 Granted read: rspN_valid=1 exactly one cycle after grant for the granting requester only; rspN_rdata=sram_dout in that cycle; otherwise rspN_rdata=0.
REQ-029 Writes SHALL produce no response; sram_dout after a write cycle SHALL be ignored.
REQ-030 Write with wmask=0 SHALL be forwarded unchanged (no memory change, no special case).
REQ-031 Write at cycle t followed by read of same address at t+1 (either requester) SHALL return the written bytes.
REQ-032 Back-to-back reads SHALL sustain one response per cycle.
REQ-033 Requester holding valid while not ready SHALL keep its command stable; block does not buffer ungranted commands.

Reset
REQ-034 While rst=1: sram_we=0, sram_wmask=0, reqN_ready=0, rspN_valid=0, rspN_rdata=0, init_done=0.
REQ-035 Reset in RUN or mid-INIT SHALL abort in-flight read responses (no rspN_valid the next cycle), clear priority to req0, and restart INIT at address 0 in the first cycle after rst falls.

Verification
REQ-036 Reset release, no requests -> 64 writes addr 0..63, din 0, wmask 4'hF; init_done=1 on cycle 65; readback of addr 63 returns 0.
REQ-037 After init, req0 write addr 5 wdata 32'hDEADBEEF wmask 4'hF, next cycle req1 read addr 5 -> rsp1_valid one cycle later, rsp1_rdata 32'hDEADBEEF, rsp0_valid stays 0.
REQ-038 Both valid reads continuously for 6 cycles -> grants alternate 0,1,0,1,0,1; each rsp on the matching port one cycle after its grant.
REQ-039 Addr 9 holds 32'h11223344; write wmask 4'b0101 wdata 32'hAABBCCDD -> read returns 32'h11BB33DD.
REQ-040 Assert rst at INIT counter 20 for one cycle -> init restarts at addr 0, init_done low for 64 further cycles.
REQ-041 Read granted in cycle t, rst=1 at t+1 -> rspN_valid=0 at t+1 and t+2, next INIT write at addr 0 in t+2.
